// File: rtl/data_hold_checker_pkg.sv
// Shared types and helpers for the data_hold_checker run-length checker.
// Optional assertions are enabled by defining DATA_HOLD_CHECKER_ASSERT_EN.
package data_hold_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHORT = 2'd1,
    OK    = 2'd2,
    OVER  = 2'd3
  } hold_state_e;

  // Run counter must hold the larger bound plus one step without wrapping.
  function automatic int run_len_width(input int min_hold, input int max_hold);
    int m;
    m = (max_hold > min_hold) ? max_hold : min_hold;
    return $clog2(m + 2);
  endfunction

endpackage

// File: rtl/data_hold_channel.sv
// One monitored channel: run-length FSM, error pulses, sticky flag and counter.
// Defining DATA_HOLD_CHECKER_ASSERT_EN adds concurrent assertions mirroring the FSM.
//
//  state | meaning
//  IDLE  | data low, no run in progress
//  SHORT | run in progress, fewer than MIN_HOLD high samples so far
//  OK    | run has met MIN_HOLD and not exceeded MAX_HOLD
//  OVER  | run exceeded MAX_HOLD; waits for data to fall
module data_hold_channel
  import data_hold_checker_pkg::*;
#(
  parameter int MIN_HOLD = 2,
  parameter int MAX_HOLD = 0,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             data,
  output logic             err_min,
  output logic             err_max,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int LEN_W = run_len_width(MIN_HOLD, MAX_HOLD);
  localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_HOLD);
  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  hold_state_e      r_state, w_state_nxt;
  logic [LEN_W-1:0] r_len, w_len_nxt, w_len_inc;
  logic             w_min_evt, w_max_evt, w_evt;
  logic             r_err_min, r_err_max, r_sticky;
  logic [CNT_W-1:0] r_cnt;

  assign w_len_inc = r_len + LEN_W'(1);
  assign w_evt     = w_min_evt | w_max_evt;

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_min_evt   = 1'b0;
    w_max_evt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (data) begin
          w_len_nxt   = LEN_W'(1);
          w_state_nxt = (MIN_HOLD == 1) ? OK : SHORT;
        end
      end
      SHORT: begin
        if (data) begin
          w_len_nxt = w_len_inc;
          if (w_len_inc == MIN_L) w_state_nxt = OK;
        end else begin
          w_min_evt   = 1'b1;
          w_len_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end
      OK: begin
        if (data) begin
          if (MAX_HOLD != 0 && r_len == MAX_L) begin
            w_max_evt   = 1'b1;
            w_state_nxt = OVER;
          end else if (MAX_HOLD != 0) begin
            w_len_nxt = w_len_inc;
          end
          // with no upper bound the counter parks at MIN_HOLD
        end else begin
          w_len_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end
      OVER: begin
        if (!data) begin
          w_len_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_len_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
    end
  end

  // clear is applied before an event on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_min <= 1'b0;
      r_err_max <= 1'b0;
      r_sticky  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_err_min <= w_min_evt;
      r_err_max <= w_max_evt;
      if (clear) begin
        r_sticky <= w_evt;
        r_cnt    <= w_evt ? CNT_W'(1) : '0;
      end else if (w_evt) begin
        r_sticky <= 1'b1;
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign err_min    = r_err_min;
  assign err_max    = r_err_max;
  assign err_sticky = r_sticky;
  assign err_cnt    = r_cnt;

`ifdef DATA_HOLD_CHECKER_ASSERT_EN
  a_min_hold: assert property (@(posedge clk) disable iff (reset)
    !(r_state == SHORT && !data))
    else $error("%m: run shorter than MIN_HOLD, L=%0d", r_len);

  a_max_hold: assert property (@(posedge clk) disable iff (reset)
    !(MAX_HOLD != 0 && r_state == OK && data && r_len == MAX_L))
    else $error("%m: run longer than MAX_HOLD, L=%0d", w_len_inc);
`endif

endmodule

// File: rtl/data_hold_checker.sv
// Multi-channel bindable run-length checker; one data_hold_channel per data bit.
// Define DATA_HOLD_CHECKER_ASSERT_EN to compile per-channel concurrent assertions.
module data_hold_checker
  import data_hold_checker_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int MIN_HOLD = 2,
  parameter int MAX_HOLD = 0,
  parameter int CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [NUM_CH-1:0]       data,
  output logic [NUM_CH-1:0]       err_min,
  output logic [NUM_CH-1:0]       err_max,
  output logic [NUM_CH-1:0]       err_sticky,
  output logic [NUM_CH*CNT_W-1:0] err_cnt
);

  if (NUM_CH < 1 || MIN_HOLD < 1 || (MAX_HOLD != 0 && MAX_HOLD < MIN_HOLD)) begin : g_param_err
    $fatal(1, "data_hold_checker: illegal NUM_CH/MIN_HOLD/MAX_HOLD combination");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    data_hold_channel #(
      .MIN_HOLD (MIN_HOLD),
      .MAX_HOLD (MAX_HOLD),
      .CNT_W    (CNT_W)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .data       (data[i]),
      .err_min    (err_min[i]),
      .err_max    (err_max[i]),
      .err_sticky (err_sticky[i]),
      .err_cnt    (err_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_data_hold_checker.sv
// Bench for data_hold_checker: two configurations driven by shared stimulus and
// checked every cycle against a run-length reference model.
module tb_data_hold_checker;

  localparam int NCH = 4;
  // instance 0: MIN=3 MAX=5 CNT_W=2 ; instance 1: MIN=2 MAX=0 CNT_W=8
  localparam int MN0 = 3, MX0 = 5, CW0 = 2;
  localparam int MN1 = 2, MX1 = 0, CW1 = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic [NCH-1:0] data = '0;

  logic [NCH-1:0]     a_min, a_max, a_stk, b_min, b_max, b_stk;
  logic [NCH*CW0-1:0] a_cnt;
  logic [NCH*CW1-1:0] b_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  int run  [2][NCH];
  int cnt  [2][NCH];
  bit stk  [2][NCH];
  bit emin [2][NCH];
  bit emax [2][NCH];

  data_hold_checker #(.NUM_CH(NCH), .MIN_HOLD(MN0), .MAX_HOLD(MX0), .CNT_W(CW0)) u_a (
    .clk(clk), .reset(reset), .clear(clear), .data(data),
    .err_min(a_min), .err_max(a_max), .err_sticky(a_stk), .err_cnt(a_cnt));

  data_hold_checker #(.NUM_CH(NCH), .MIN_HOLD(MN1), .MAX_HOLD(MX1), .CNT_W(CW1)) u_b (
    .clk(clk), .reset(reset), .clear(clear), .data(data),
    .err_min(b_min), .err_max(b_max), .err_sticky(b_stk), .err_cnt(b_cnt));

  initial forever #5 clk = ~clk;

  // Reference: run length is a plain count of consecutive high samples.
  task automatic model_edge();
    int mn, mx, cmax;
    bit ev;
    for (int k = 0; k < 2; k++) begin
      mn   = (k == 0) ? MN0 : MN1;
      mx   = (k == 0) ? MX0 : MX1;
      cmax = (k == 0) ? (1 << CW0) - 1 : (1 << CW1) - 1;
      for (int c = 0; c < NCH; c++) begin
        emin[k][c] = 1'b0;
        emax[k][c] = 1'b0;
        if (reset) begin
          run[k][c] = 0; cnt[k][c] = 0; stk[k][c] = 1'b0;
        end else begin
          if (data[c]) begin
            run[k][c]++;
            if (mx != 0 && run[k][c] == mx + 1) emax[k][c] = 1'b1;
          end else begin
            if (run[k][c] > 0 && run[k][c] < mn) emin[k][c] = 1'b1;
            run[k][c] = 0;
          end
          ev = emin[k][c] | emax[k][c];
          if (clear) begin
            cnt[k][c] = 0; stk[k][c] = 1'b0;
          end
          if (ev) begin
            stk[k][c] = 1'b1;
            if (cnt[k][c] < cmax) cnt[k][c]++;
          end
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string step);
    logic [NCH-1:0] xa_min, xa_max, xa_stk, xb_min, xb_max, xb_stk;
    logic [NCH*CW0-1:0] xa_cnt;
    logic [NCH*CW1-1:0] xb_cnt;
    for (int c = 0; c < NCH; c++) begin
      xa_min[c] = emin[0][c]; xa_max[c] = emax[0][c]; xa_stk[c] = stk[0][c];
      xb_min[c] = emin[1][c]; xb_max[c] = emax[1][c]; xb_stk[c] = stk[1][c];
      xa_cnt[c*CW0 +: CW0] = CW0'(cnt[0][c]);
      xb_cnt[c*CW1 +: CW1] = CW1'(cnt[1][c]);
    end
    check({step, " a.err_min"},    32'(a_min), 32'(xa_min));
    check({step, " a.err_max"},    32'(a_max), 32'(xa_max));
    check({step, " a.err_sticky"}, 32'(a_stk), 32'(xa_stk));
    check({step, " a.err_cnt"},    32'(a_cnt), 32'(xa_cnt));
    check({step, " b.err_min"},    32'(b_min), 32'(xb_min));
    check({step, " b.err_max"},    32'(b_max), 32'(xb_max));
    check({step, " b.err_sticky"}, 32'(b_stk), 32'(xb_stk));
    check({step, " b.err_cnt"},    32'(b_cnt), 32'(xb_cnt));
  endtask

  task automatic cyc(input string step, input logic [NCH-1:0] d, input logic rst, input logic clr);
    @(negedge clk);
    data = d; reset = rst; clear = clr;
    @(posedge clk);
    model_edge();
    #1;
    check_all(step);
  endtask

  initial begin
    logic [NCH-1:0] rd;
    // reset
    cyc("reset", '0, 1'b1, 1'b0);
    cyc("reset", '0, 1'b1, 1'b0);
    cyc("idle",  '0, 1'b0, 1'b0);
    check("reset a.cnt zero", 32'(a_cnt), 32'd0);

    // ch0: 2-cycle run, short for instance a
    repeat (2) cyc("ch0 short", 4'b0001, 1'b0, 1'b0);
    cyc("ch0 fall", 4'b0000, 1'b0, 1'b0);
    check("ch0 err_min pulse", 32'(a_min[0]), 32'd1);
    cyc("ch0 after", 4'b0000, 1'b0, 1'b0);
    check("ch0 err_min one cycle", 32'(a_min[0]), 32'd0);

    // ch1: 7-cycle run, too long for instance a
    repeat (7) cyc("ch1 long", 4'b0010, 1'b0, 1'b0);
    cyc("ch1 fall", 4'b0000, 1'b0, 1'b0);
    check("ch1 err_cnt", 32'(a_cnt[1*CW0 +: CW0]), 32'd1);

    // ch2: exactly 3 and exactly 5 cycles
    repeat (3) cyc("ch2 run3", 4'b0100, 1'b0, 1'b0);
    cyc("ch2 gap", 4'b0000, 1'b0, 1'b0);
    repeat (5) cyc("ch2 run5", 4'b0100, 1'b0, 1'b0);
    cyc("ch2 gap", 4'b0000, 1'b0, 1'b0);
    check("ch2 boundary cnt", 32'(a_cnt[2*CW0 +: CW0]), 32'd0);

    // ch3: 300-cycle run; no upper bound on instance b
    repeat (300) cyc("ch3 long", 4'b1000, 1'b0, 1'b0);
    cyc("ch3 fall", 4'b0000, 1'b0, 1'b0);
    check("ch3 b no err_max", 32'(b_stk[3]), 32'd0);

    // ch0: five short runs saturate instance a, then clear with a sixth
    repeat (5) begin
      cyc("ch0 sat", 4'b0001, 1'b0, 1'b0);
      cyc("ch0 sat", 4'b0000, 1'b0, 1'b0);
    end
    check("ch0 saturated", 32'(a_cnt[0 +: CW0]), 32'd3);
    cyc("ch0 sixth", 4'b0001, 1'b0, 1'b0);
    cyc("ch0 clear+err", 4'b0000, 1'b0, 1'b1);
    check("clear+err cnt", 32'(a_cnt[0 +: CW0]), 32'd1);
    check("clear+err sticky", 32'(a_stk[0]), 32'd1);

    // reset mid-run discards the run
    cyc("mid run", 4'b0001, 1'b0, 1'b0);
    cyc("mid reset", 4'b0000, 1'b1, 1'b0);
    cyc("mid reset", 4'b0001, 1'b1, 1'b0);
    cyc("post reset", 4'b0000, 1'b0, 1'b0);
    check("no err after reset", 32'(a_min), 32'd0);
    repeat (2) cyc("fresh run", 4'b0001, 1'b0, 1'b0);
    cyc("fresh fall", 4'b0000, 1'b0, 1'b0);
    check("fresh run err_min", 32'(a_min[0]), 32'd1);

    // random runs with occasional clear and reset
    rd = '0;
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 3) == 0) rd[c] = ~rd[c];
      cyc("random", rd, ($urandom_range(0, 199) == 0), ($urandom_range(0, 29) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
